sto_bram_rd_arb: RTL and testbench
==================================

// Module: sto_bram_rd_arb
// PURPOSE
// - Shares one 64-bit BRAM read port between NREQ readers, e.g. the activation and weight loaders when both map onto the same bank.
// - Round-robin arbitration with burst hold.
// - Tracks outstanding reads in a tag FIFO so returned data is routed back to the issuing reader.
// - Sits between the loaders and the bce/braddr/brdata/brvalid bank port in the sto top level.
// PARAMETERS
// NREQ       2    number of requesters (2..4)
// AW         15   BRAM address width
// DW         64   BRAM data width
// MAX_OUT    4    max reads issued but not yet returned (tag FIFO depth, power of 2)
// BURST_MAX  16   max consecutive accepted beats per owner before rotation is considered
// PORTS
// clk        in   1          clock, all logic on rising edge
// rst_n      in   1          synchronous active-low reset
// req_ce     in   NREQ       read request per requester; held with req_addr until granted
// req_addr   in   NREQ*AW    request addresses, requester i at [i*AW +: AW]
// req_gnt    out  NREQ       combinational grant, at most one bit set
// rsp_data   out  DW         returned read data, shared by all requesters
// rsp_valid  out  NREQ       one-hot: rsp_data belongs to requester i this cycle
// bce        out  1          BRAM read enable, registered
// braddr     out  AW         BRAM read address, registered
// brdata     in   DW         BRAM read data
// brvalid    in   1          BRAM read data valid, in issue order
// outstanding out clog2(MAX_OUT+1)  reads in flight
// err_unexp  out  1          sticky: brvalid seen with tag FIFO empty
// BEHAVIOUR
// - Reset: synchronous, rst_n low at a clk edge clears everything.
//   - Outputs after reset: bce=0, braddr=0, rsp_valid=0, rsp_data=0, outstanding=0, err_unexp=0.
//   - FSM goes to IDLE, rr pointer=0, beat counter=0, tag FIFO empty.
//   - Reset mid-operation discards all in-flight tags. A later brvalid then sets err_unexp and its data is dropped.
// - Accept: a beat is accepted when req_ce[i] & req_gnt[i].
//   - Next cycle: bce=1, braddr=that address, and tag i is pushed to the FIFO in the same edge.
//   - bce=0 in any cycle with no accept in the previous cycle.
// - Capacity: req_gnt is all zero unless (outstanding < MAX_OUT) || brvalid. A same-cycle pop frees a slot.
// - Return: on brvalid, the tag is popped; next cycle rsp_valid[tag]=1 and rsp_data=brdata.
//   - Latency accept->rsp_valid = 1 + BRAM latency + 1.
// - outstanding: +1 per accept, -1 per valid pop; both in one cycle leaves it unchanged.
// - FSM IDLE:
//   - No owner.
//   - If any req_ce is set and capacity allows, grant the first requester at or after the rr pointer (cyclic search).
//   - Go to OWN(owner=i), beats=1.
// - FSM OWN:
//   - Owner keeps the grant while req_ce[owner] is high, capacity allows and beats < BURST_MAX; beats += 1 per accept.
//   - Owner drops req_ce: rr = owner+1 mod NREQ, and re-arbitrate in the same cycle as IDLE would.
//     - If nobody requests: go to IDLE.
//   - beats == BURST_MAX: rr = owner+1.
//     - Another requester is waiting: it wins, beats=1.
//     - Only the owner is requesting: it is re-granted, beats=1.
//   - Capacity stall: no grant, state and beats hold, no rotation.
// - Grant is a function of registered state and the current req_ce only; there is no path from brdata.
// - Simultaneous accept and brvalid with FIFO full: pop and push both happen, and FIFO order is preserved.
// - Widths: beats counter is clog2(BURST_MAX+1) bits; FIFO pointers wrap modulo MAX_OUT; the tag is clog2(NREQ) bits.
// STRUCTURE
// - sto_pkg: STO_AW=15, STO_DW=64 and the arb FSM state encoding (ARB_IDLE, ARB_OWN).
// - Sub-module sto_tag_fifo holds the tag FIFO.
//   - Parameters: depth, width; ports: push, pop, full, empty, count.
//   - pop on empty is ignored and flagged.
// - Arbiter FSM, rr pointer, beat counter and the registered issue/return stages stay in this module.
// TESTING
// - Single reader: req0 addr 0x0010 for 3 beats, BRAM latency 2.
//   - bce/braddr 0x10,0x11,0x12 one cycle after each gnt.
//   - rsp_valid=2'b01 for 3 beats, 4 cycles after each accept.
// - Contention, both req_ce held, BURST_MAX=4, rr=0.
//   - Grants 0,0,0,0,1,1,1,1,0...
//   - rsp_valid tags follow in the same order.
// - Owner drop: req0 drops after 2 beats while req1 waits -> req1 granted in the same cycle req0 goes low.
// - Capacity: MAX_OUT=4, BRAM withholds brvalid.
//   - 4 accepts, then gnt=0 and outstanding=4.
//   - First brvalid -> grant in that cycle, outstanding stays 4.
// - Reset mid-operation: rst_n low for 1 cycle with 3 in flight.
//   - Outputs go to reset values.
//   - The next stray brvalid sets err_unexp=1 with no rsp_valid.
// - Randomised address/latency (1..5) soak with a scoreboard: every requester gets exactly its own data, in order.

Source files
------------

// File: rtl/sto_pkg.sv
// Shared constants and arbiter state encoding for the sto BRAM access path.
package sto_pkg;
  localparam int STO_AW = 15;
  localparam int STO_DW = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/sto_tag_fifo.sv
// Small FIFO holding requester tags of reads that are issued but not yet returned.
module sto_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             pop_err
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is fine when the same edge pops a slot free
  assign do_push = push & (~full | do_pop);
  assign pop_err = pop & empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sto_bram_rd_arb.sv
// Round-robin arbiter with burst hold sharing one BRAM read port; a tag FIFO
// routes returned data back to the requester that issued the read.
module sto_bram_rd_arb
  import sto_pkg::*;
#(
  parameter  int NREQ      = 2,
  parameter  int AW        = STO_AW,
  parameter  int DW        = STO_DW,
  parameter  int MAX_OUT   = 4,
  parameter  int BURST_MAX = 16,
  localparam int CW        = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_ce,
  input  logic [NREQ*AW-1:0]  req_addr,
  output logic [NREQ-1:0]     req_gnt,
  output logic [DW-1:0]       rsp_data,
  output logic [NREQ-1:0]     rsp_valid,
  output logic                bce,
  output logic [AW-1:0]       braddr,
  input  logic [DW-1:0]       brdata,
  input  logic                brvalid,
  output logic [CW-1:0]       outstanding,
  output logic                err_unexp
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_t                 st_q, st_d;
  logic [TW-1:0]              rr_q, rr_d, owner_q, owner_d, owner_nxt, gnt_idx, tag_out;
  logic [BW-1:0]              beats_q, beats_d;
  logic [TW:0]                pick_rr, pick_rot;
  logic [NREQ-1:0][AW-1:0]    addr_v;
  logic                       cap_ok, acc, pop_ok, pop_err, fifo_full, fifo_empty;

  // {hit, index} of the first requester at or after start, searching cyclically
  function automatic logic [TW:0] rr_pick(input logic [NREQ-1:0] r, input logic [TW-1:0] start);
    logic [TW:0]   res;
    logic [TW-1:0] jj;
    int            j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = TW'(j);
      if (r[jj]) res = {1'b1, jj};
    end
    return res;
  endfunction

  assign addr_v    = req_addr;
  assign owner_nxt = (owner_q == TW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  // a return in this cycle frees a slot, so grant never depends on brdata
  assign cap_ok    = ~fifo_full | brvalid;
  assign acc       = |(req_ce & req_gnt);
  assign pop_ok    = brvalid & ~fifo_empty;

  always_comb begin
    req_gnt  = '0;
    gnt_idx  = '0;
    st_d     = st_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    beats_d  = beats_q;
    pick_rr  = rr_pick(req_ce, rr_q);
    pick_rot = rr_pick(req_ce, owner_nxt);
    if (cap_ok) begin
      case (st_q)
        ARB_IDLE: begin
          if (pick_rr[TW]) begin
            gnt_idx          = pick_rr[TW-1:0];
            req_gnt[gnt_idx] = 1'b1;
            st_d             = ARB_OWN;
            owner_d          = gnt_idx;
            beats_d          = BW'(1);
          end
        end
        ARB_OWN: begin
          if (req_ce[owner_q] && beats_q < BW'(BURST_MAX)) begin
            gnt_idx          = owner_q;
            req_gnt[owner_q] = 1'b1;
            beats_d          = beats_q + 1'b1;
          end else begin
            // owner dropped or burst exhausted: rotate and re-arbitrate now
            rr_d = owner_nxt;
            if (pick_rot[TW]) begin
              gnt_idx          = pick_rot[TW-1:0];
              req_gnt[gnt_idx] = 1'b1;
              owner_d          = gnt_idx;
              beats_d          = BW'(1);
            end else begin
              st_d    = ARB_IDLE;
              beats_d = '0;
            end
          end
        end
        default: st_d = ARB_IDLE;
      endcase
    end
  end

  sto_tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(TW)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (acc),
    .din     (gnt_idx),
    .pop     (brvalid),
    .dout    (tag_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding),
    .pop_err (pop_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= ARB_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      beats_q   <= '0;
      bce       <= 1'b0;
      braddr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_unexp <= 1'b0;
    end else begin
      st_q    <= st_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      bce     <= acc;
      if (acc) braddr <= addr_v[gnt_idx];
      rsp_valid <= '0;
      if (pop_ok) begin
        rsp_valid[tag_out] <= 1'b1;
        rsp_data           <= brdata;
      end
      if (pop_err) err_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sto_bram_rd_arb.sv
// Directed and soak bench for sto_bram_rd_arb with an in-order BRAM responder and scoreboard.
module tb_sto_bram_rd_arb;
  localparam int NREQ = 2, AW = 15, DW = 64, MAX_OUT = 4, BM = 4;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]     req_ce, req_gnt, rsp_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [DW-1:0]       rsp_data, brdata;
  logic                bce, brvalid, err_unexp;
  logic [AW-1:0]       braddr;
  logic [2:0]          outstanding;
  logic                ce_v [NREQ];
  logic [AW-1:0]       ad_v [NREQ];

  sto_bram_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .req_ce(req_ce), .req_addr(req_addr), .req_gnt(req_gnt),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .bce(bce), .braddr(braddr),
    .brdata(brdata), .brvalid(brvalid), .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_ce   = '0;
    req_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ce[i]             = ce_v[i];
      req_addr[i*AW +: AW]  = ad_v[i];
    end
  end

  int nerr = 0, nchk = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [AW-1:0] a);
    return {16'hBEEF, 1'b0, a, 16'hC0DE, 1'b0, a};
  endfunction

  // BRAM responder: in-order returns, per-read latency in [lat_min, lat_max]
  bit            auto_bram = 1'b1;
  int            lat_min = 2, lat_max = 2, rcyc = 0, last_due = 0;
  int            pq_due[$];
  logic [AW-1:0] pq_adr[$];
  initial begin
    int d;
    brvalid = 1'b0;
    brdata  = '0;
    forever begin
      @(posedge clk); #2;
      rcyc++;
      if (auto_bram) begin
        if (bce === 1'b1) begin
          d = rcyc + int'($urandom_range(lat_max, lat_min));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pq_due.push_back(d);
          pq_adr.push_back(braddr);
        end
        if (pq_due.size() > 0 && pq_due[0] == rcyc) begin
          brvalid = 1'b1;
          brdata  = data_of(pq_adr[0]);
          void'(pq_due.pop_front());
          void'(pq_adr.pop_front());
        end else begin
          brvalid = 1'b0;
        end
      end
    end
  end

  // Model: global issue-order queue of (tag, addr); outputs compared every cycle
  int            ncyc = 0, mq_tag[$], acc_idx[$], acc_cyc[$], bce_cyc[$], rsp_tag[$], rsp_cyc[$];
  logic [AW-1:0] mq_adr[$], bce_adr[$], p_addr, p_raddr;
  logic [63:0]   rsp_dat[$];
  bit            p_acc = 0, p_pop = 0, exp_err = 0;
  int            p_tag = 0, rsp_n0 = 0, rsp_n1 = 0;
  always @(negedge clk) begin
    logic [63:0] one;
    int          idx;
    one = 64'd1;
    ncyc++;
    if (!rst_n) begin
      mq_tag.delete(); mq_adr.delete();
      p_acc = 0; p_pop = 0; exp_err = 0;
    end else begin
      chk("bce", bce, p_acc);
      if (p_acc) chk("braddr", braddr, p_addr);
      if (p_pop) begin
        chk("rsp_valid", rsp_valid, one << p_tag);
        chk("rsp_data", rsp_data, data_of(p_raddr));
        rsp_tag.push_back(p_tag); rsp_cyc.push_back(ncyc); rsp_dat.push_back(rsp_data);
        if (p_tag == 0) rsp_n0++; else rsp_n1++;
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
      chk("outstanding", outstanding, mq_tag.size());
      chk("err_unexp", err_unexp, exp_err);
      chk("gnt_legal", ((req_gnt & ~req_ce) == '0) && $onehot0(req_gnt), 1);
      if (!(mq_tag.size() < MAX_OUT || brvalid)) chk("gnt_capacity", req_gnt, 0);
      if (bce) begin bce_cyc.push_back(ncyc); bce_adr.push_back(braddr); end
      p_pop = brvalid && mq_tag.size() > 0;
      if (p_pop) begin p_tag = mq_tag.pop_front(); p_raddr = mq_adr.pop_front(); end
      if (brvalid && !p_pop) exp_err = 1;
      p_acc = |(req_ce & req_gnt);
      if (p_acc) begin
        idx    = req_gnt[1] ? 1 : 0;
        p_addr = req_addr[idx*AW +: AW];
        mq_tag.push_back(idx); mq_adr.push_back(p_addr);
        acc_idx.push_back(idx); acc_cyc.push_back(ncyc);
      end
    end
  end

  task automatic clear_logs();
    acc_idx.delete(); acc_cyc.delete(); bce_cyc.delete(); bce_adr.delete();
    rsp_tag.delete(); rsp_cyc.delete(); rsp_dat.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) ce_v[i] = 1'b0;
    brvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pq_due.delete(); pq_adr.delete();
    clear_logs();
  endtask

  // Hold req_ce[i] until n beats are accepted; address advances per accept
  task automatic rd_burst(input int i, input int base, input int n);
    int k = 0, t = 0;
    ce_v[i] = 1'b1;
    ad_v[i] = AW'(base);
    while (k < n && t < 500) begin
      @(negedge clk);
      if (req_gnt[i]) k++;
      @(posedge clk); #1;
      ad_v[i] = AW'(base + k);
      t++;
    end
    ce_v[i] = 1'b0;
    if (t >= 500) chk("burst_timeout", k, n);
  endtask

  task automatic drain();
    int t = 0;
    while ((outstanding != 0 || pq_due.size() != 0) && t < 300) begin
      @(negedge clk); t++;
    end
    chk("drain_in_time", t < 300, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cyc_q(input string nm, input int q[$], input int k, input int exp);
    if (q.size() > k) chk(nm, q[k], exp);
    else chk({nm, "_missing"}, q.size(), k + 1);
  endtask

  int exp_ctn [16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
  int exp_drop [5] = '{0,0,1,1,1};

  initial begin
    int tot0, tot1, n0, n1, g;
    for (int i = 0; i < NREQ; i++) begin ce_v[i] = 1'b0; ad_v[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_bce", bce, 0);
    chk("rst_braddr", braddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexp, 0);
    @(posedge clk); #1;

    // single reader, latency 2
    lat_min = 2; lat_max = 2;
    do_reset();
    rd_burst(0, 'h10, 3);
    drain();
    chk("t1_nacc", acc_idx.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (acc_cyc.size() > k) begin
        cyc_q("t1_bce_cyc", bce_cyc, k, acc_cyc[k] + 1);
        cyc_q("t1_rsp_cyc", rsp_cyc, k, acc_cyc[k] + 4);
        cyc_q("t1_rsp_tag", rsp_tag, k, 0);
        if (k > 0) chk("t1_b2b", acc_cyc[k], acc_cyc[k-1] + 1);
      end
      if (bce_adr.size() > k) chk("t1_braddr", bce_adr[k], 15'h10 + 15'(k));
    end
    if (rsp_dat.size() > 0) chk("t1_rsp_data0", rsp_dat[0], 64'hBEEF_0010_C0DE_0010);
    else chk("t1_rsp_data0_missing", 0, 1);

    // contention with burst hold of 4
    do_reset();
    fork
      rd_burst(0, 'h100, 8);
      rd_burst(1, 'h200, 8);
    join
    drain();
    chk("t2_nacc", acc_idx.size(), 16);
    for (int k = 0; k < 16; k++) begin
      cyc_q("t2_gnt_order", acc_idx, k, exp_ctn[k]);
      cyc_q("t2_rsp_order", rsp_tag, k, exp_ctn[k]);
    end

    // owner drops while the other waits
    do_reset();
    fork
      rd_burst(0, 'h300, 2);
      rd_burst(1, 'h400, 3);
    join
    drain();
    for (int k = 0; k < 5; k++) cyc_q("t3_gnt_order", acc_idx, k, exp_drop[k]);
    if (acc_cyc.size() > 2) chk("t3_same_cycle", acc_cyc[2], acc_cyc[1] + 1);

    // capacity: BRAM withholds data
    auto_bram = 1'b0;
    do_reset();
    ce_v[0] = 1'b1; ad_v[0] = 15'h500;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t4_fill_gnt", req_gnt, 2'b01);
      @(posedge clk); #1; ad_v[0] = 15'h501 + 15'(k);
    end
    repeat (2) begin
      @(negedge clk); chk("t4_stall_gnt", req_gnt, 0); chk("t4_stall_out", outstanding, 4);
      @(posedge clk); #1;
    end
    brvalid = 1'b1; brdata = data_of(15'h500);
    @(negedge clk); chk("t4_pop_gnt", req_gnt, 2'b01); chk("t4_pop_out", outstanding, 4);
    @(posedge clk); #1; brvalid = 1'b0; ad_v[0] = 15'h505;
    @(negedge clk); chk("t4_after_out", outstanding, 4); chk("t4_after_gnt", req_gnt, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1; ce_v[0] = 1'b0; brvalid = 1'b1; brdata = data_of(15'h500 + 15'(k));
    end
    @(posedge clk); #1; brvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("t4_drained", outstanding, 0);
    chk("t4_nrsp", rsp_tag.size(), 5);
    @(posedge clk); #1;

    // reset with three reads in flight, then a stray return
    do_reset();
    ce_v[0] = 1'b1; ad_v[0] = 15'h600;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t5_gnt", req_gnt, 2'b01);
      @(posedge clk); #1; ad_v[0] = 15'h601 + 15'(k);
    end
    ce_v[0] = 1'b0;
    @(negedge clk); chk("t5_inflight", outstanding, 3);
    do_reset();
    @(negedge clk);
    chk("t5_rst_bce", bce, 0);
    chk("t5_rst_braddr", braddr, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_outstanding", outstanding, 0);
    chk("t5_rst_err", err_unexp, 0);
    @(posedge clk); #1; brvalid = 1'b1; brdata = data_of(15'h600);
    @(posedge clk); #1; brvalid = 1'b0;
    @(negedge clk); chk("t5_err_set", err_unexp, 1); chk("t5_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;

    // randomised soak, latency 1..5
    auto_bram = 1'b1; lat_min = 1; lat_max = 5;
    do_reset();
    rsp_n0 = 0; rsp_n1 = 0; tot0 = 0; tot1 = 0;
    for (int r = 0; r < 8; r++) begin
      n0 = int'($urandom_range(20, 1));
      n1 = int'($urandom_range(20, 1));
      g  = int'($urandom_range(3, 0));
      tot0 += n0; tot1 += n1;
      fork
        rd_burst(0, int'($urandom_range(32'h7000, 0)), n0);
        begin
          repeat (g) begin @(posedge clk); #1; end
          rd_burst(1, int'($urandom_range(32'h7000, 0)), n1);
        end
      join
    end
    drain();
    chk("soak_rsp0", rsp_n0, tot0);
    chk("soak_rsp1", rsp_n1, tot1);
    chk("soak_err", err_unexp, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
